nbit_addsub_seq: RTL

- Multi-cycle, parametrised adder/subtractor/comparator for the processor ALU path.
- Next generation of the combinational N-bit subtractor.
- Adds add/sub/carry-chain/compare modes and a start/done handshake.
- Processes the N-bit operands in W-bit slices, LSB first, one slice per clock, so wide datapaths close timing with a short carry chain.
- Produces result plus carry (NOT-borrow for subtract), zero, overflow and negative flags.

---
 rtl/nbit_addsub_seq_if.sv | 29 ++
 rtl/nbit_addsub_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/nbit_addsub_seq_if.sv
// Request/response bundle for the sliced adder/subtractor/comparator.
// Master issues operations; slave returns the result and the flags.
interface nbit_addsub_seq_if #(
  parameter int unsigned N = 32
);
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cry_flag;
  logic         zr_flag;
  logic         of_flag;
  logic         neg_flag;

  modport master (
    output start, op, a, b, c_in,
    input  ready, busy, done, result, cry_flag, zr_flag, of_flag, neg_flag
  );

  modport slave (
    input  start, op, a, b, c_in,
    output ready, busy, done, result, cry_flag, zr_flag, of_flag, neg_flag
  );
endinterface

// File: rtl/nbit_addsub_seq.sv
// Multi-cycle N-bit add/sub/compare: processes W-bit slices LSB first, one per clock,
// so only a W-bit carry chain sits between registers.
module nbit_addsub_seq #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input  logic               clk,
  input  logic               rst,
  nbit_addsub_seq_if.slave   bus
);
  localparam int unsigned CHUNKS = N / W;
  localparam int unsigned KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  work;
  logic          a_msb;
  logic          b_msb;
  logic          carry;
  logic          zr_acc;
  logic          is_cmp;
  logic [KW-1:0] k;

  logic [W:0]    slice_sum;
  logic [N-1:0]  next_work;
  logic          slice_zero;
  logic          is_sub;
  logic          carry_init;

  // Operand shift registers always present the current slice in their low W bits.
  always_comb begin
    slice_sum  = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + (W+1)'(carry);
    slice_zero = ~|slice_sum[W-1:0];
  end

  // Sum slices enter at the top of the working register, so the result is aligned after the last one.
  generate
    if (CHUNKS == 1) begin : g_single
      assign next_work = slice_sum[W-1:0];
    end else begin : g_multi
      assign next_work = {slice_sum[W-1:0], work[N-1:W]};
    end
  endgenerate

  always_comb begin
    is_sub     = (bus.op == 3'd1) || (bus.op == 3'd3) || (bus.op == 3'd4);
    carry_init = 1'b0;
    case (bus.op)
      3'd1, 3'd4: carry_init = 1'b1;
      3'd2, 3'd3: carry_init = bus.c_in;
      default:    carry_init = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      work         <= '0;
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      carry        <= 1'b0;
      zr_acc       <= 1'b0;
      is_cmp       <= 1'b0;
      k            <= '0;
      bus.ready    <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.cry_flag <= 1'b0;
      bus.zr_flag  <= 1'b0;
      bus.of_flag  <= 1'b0;
      bus.neg_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_q       <= bus.a;
            b_q       <= is_sub ? ~bus.b : bus.b;
            a_msb     <= bus.a[N-1];
            b_msb     <= is_sub ? ~bus.b[N-1] : bus.b[N-1];
            carry     <= carry_init;
            zr_acc    <= 1'b1;
            is_cmp    <= (bus.op == 3'd4);
            k         <= '0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q    <= a_q >> W;
          b_q    <= b_q >> W;
          work   <= next_work;
          carry  <= slice_sum[W];
          zr_acc <= zr_acc & slice_zero;
          k      <= KW'(k + 1'b1);
          if (k == KW'(CHUNKS - 1)) begin
            state        <= S_DONE;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            bus.ready    <= 1'b1;
            bus.cry_flag <= slice_sum[W];
            bus.zr_flag  <= zr_acc & slice_zero;
            bus.neg_flag <= slice_sum[W-1];
            bus.of_flag  <= (a_msb == b_msb) && (slice_sum[W-1] != a_msb);
            if (!is_cmp) begin
              bus.result <= next_work;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
